seq_divider32: RTL and testbench



---
 rtl/seq_divider32_pkg.sv | 14 +
 rtl/seq_divider32_adder.sv | 12 +
 rtl/seq_divider32.sv | 108 ++++++++++
 tb/tb_seq_divider32.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider32_pkg.sv
// Shared constants and state encoding for the sequential divider.
// The adder and the divider top both import this package.
package seq_divider32_pkg;
    localparam int          DATA_W    = 32;
    localparam int          CNT_W     = 5;
    localparam logic [4:0]  ITER_LAST = 5'd31;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;
endpackage

// File: rtl/seq_divider32_adder.sv
// 32-bit ripple adder with carry in/out; the divider drives it as A + ~B + 1.
module adder32
    import seq_divider32_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_cin,
    output logic [DATA_W-1:0] o_sum,
    output logic              o_cout
);
    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{DATA_W{1'b0}}, i_cin};
endmodule

// File: rtl/seq_divider32.sv
// Unsigned 32-bit restoring divider, one quotient bit per clock.
// Start is sampled only in IDLE; Done pulses for one cycle with results valid.
module seq_divider32
    import seq_divider32_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_quotient,
    output logic [DATA_W-1:0] o_remainder,
    output logic              o_div_by_zero,
    output logic [1:0]        o_state
);
    state_t            r_state;
    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] r_r;
    logic [DATA_W-1:0] r_d;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_quotient;
    logic [DATA_W-1:0] r_remainder;
    logic              r_div_by_zero;

    logic [DATA_W-1:0] w_t;
    logic [DATA_W-1:0] w_diff;
    logic              w_cout;
    logic              w_ok;
    logic [DATA_W-1:0] w_r_next;
    logic [DATA_W-1:0] w_q_next;

    // Shift the next dividend bit into the partial remainder, then trial-subtract.
    assign w_t = {r_r[DATA_W-2:0], r_q[DATA_W-1]};

    adder32 u_adder (
        .i_a    (w_t),
        .i_b    (~r_d),
        .i_cin  (1'b1),
        .o_sum  (w_diff),
        .o_cout (w_cout)
    );

    // The shifted-out msb means T exceeds 32 bits, so it is always >= D.
    assign w_ok     = r_r[DATA_W-1] | w_cout;
    assign w_r_next = w_ok ? w_diff : w_t;
    assign w_q_next = {r_q[DATA_W-2:0], w_ok};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_q           <= '0;
            r_r           <= '0;
            r_d           <= '0;
            r_cnt         <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_divisor != '0) begin
                            r_q           <= i_dividend;
                            r_r           <= '0;
                            r_d           <= i_divisor;
                            r_cnt         <= '0;
                            r_quotient    <= '0;
                            r_remainder   <= '0;
                            r_div_by_zero <= 1'b0;
                        end else begin
                            r_quotient    <= DIV0_QUOT;
                            r_remainder   <= i_dividend;
                            r_div_by_zero <= 1'b1;
                        end
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // A zero divisor passes through RUN once without iterating,
                    // giving it a two-cycle latency to Done.
                    if (r_div_by_zero) begin
                        r_state <= S_DONE;
                    end else begin
                        r_r   <= w_r_next;
                        r_q   <= w_q_next;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == ITER_LAST) begin
                            r_quotient  <= w_q_next;
                            r_remainder <= w_r_next;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_DONE);
    assign o_quotient    = r_quotient;
    assign o_remainder   = r_remainder;
    assign o_div_by_zero = r_div_by_zero;
    assign o_state       = r_state;
endmodule

// File: tb/tb_seq_divider32.sv
// Self-checking bench for seq_divider32: directed cases plus randomized
// operands compared against plain integer division.
module tb_seq_divider32;
    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    seq_divider32 dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_start       (start),
        .i_dividend    (dividend),
        .i_divisor     (divisor),
        .o_busy        (busy),
        .o_done        (done),
        .o_quotient    (quotient),
        .o_remainder   (remainder),
        .o_div_by_zero (div_by_zero),
        .o_state       (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands.
    task automatic model_push(input logic [31:0] a, input logic [31:0] d);
        if (d == 0) begin
            exp_q.push_back(32'hFFFFFFFF);
            exp_q.push_back(a);
        end else begin
            exp_q.push_back(a / d);
            exp_q.push_back(a % d);
        end
    endtask

    // Drive a Start request in an IDLE cycle.
    task automatic launch(input logic [31:0] a, input logic [31:0] d);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        start    = 1'b1;
        dividend = a;
        divisor  = d;
    endtask

    // Count edges from the accepting edge (1) until Done is seen.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
        end while (!done && cyc < 100);
        if (!done) check_eq("done_timeout", 64'(cyc), 64'd0);
    endtask

    task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] d,
                                input int lat, input int exp_lat);
        logic [31:0] eq;
        logic [31:0] er;
        eq = exp_q.pop_front();
        er = exp_q.pop_front();
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_q"}, 64'(quotient), 64'(eq));
        check_eq({tag, "_r"}, 64'(remainder), 64'(er));
        check_eq({tag, "_dz"}, 64'(div_by_zero), 64'(d == 0));
        if (d != 0) begin
            check_eq({tag, "_ident"}, 64'(quotient) * 64'(d) + 64'(remainder), 64'(a));
            check_eq({tag, "_rltd"}, 64'(remainder < d), 64'd1);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] d);
        int lat;
        model_push(a, d);
        launch(a, d);
        wait_done(lat);
        check_result(tag, a, d, lat, (d == 0) ? 2 : 33);
    endtask

    initial begin
        int lat;
        logic [31:0] a;
        logic [31:0] d;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_q", 64'(quotient), 64'd0);
        check_eq("rst_r", 64'(remainder), 64'd0);
        check_eq("rst_dz", 64'(div_by_zero), 64'd0);
        check_eq("rst_state", 64'(state), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // 100 / 7 with hold check
        run_op("d100_7", 32'd100, 32'd7);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_eq("hold_done", 64'(done), 64'd0);
            check_eq("hold_busy", 64'(busy), 64'd0);
            check_eq("hold_q", 64'(quotient), 64'd14);
            check_eq("hold_r", 64'(remainder), 64'd2);
        end

        run_op("max_1", 32'hFFFFFFFF, 32'd1);
        run_op("msb", 32'h80000000, 32'hFFFFFFFF);
        run_op("d3_10", 32'd3, 32'd10);
        run_op("d5_0", 32'd5, 32'd0);
        run_op("after_dz", 32'd77, 32'd5);

        // Start held high with operands changing during RUN
        model_push(32'd1000, 32'd33);
        launch(32'd1000, 32'd33);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            check_eq("held_busy", 64'(busy), 64'd1);
            dividend = $urandom;
            divisor  = $urandom;
        end while (!done && lat < 100);
        check_result("held1", 32'd1000, 32'd33, lat, 33);
        dividend = 32'd1000;
        divisor  = 32'd1000;
        model_push(32'd1000, 32'd1000);
        @(posedge clk);
        #1;
        check_eq("held_idle_busy", 64'(busy), 64'd0);
        check_eq("held_idle_state", 64'(state), 64'd0);
        wait_done(lat);
        check_result("held2", 32'd1000, 32'd1000, lat, 33);

        // Reset during the 10th RUN cycle
        launch(32'd500, 32'd3);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check_eq("mid_state", 64'(state), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        check_eq("mid_rst_done", 64'(done), 64'd0);
        check_eq("mid_rst_q", 64'(quotient), 64'd0);
        check_eq("mid_rst_r", 64'(remainder), 64'd0);
        check_eq("mid_rst_dz", 64'(div_by_zero), 64'd0);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            check_eq("mid_no_done", 64'(done), 64'd0);
        end
        run_op("d500_3", 32'd500, 32'd3);

        // Randomized operands
        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(0, 7))
                0:       d = 32'd0;
                1:       d = $urandom_range(1, 16);
                2:       d = 32'hFFFFFFFF - $urandom_range(0, 3);
                3:       d = $urandom_range(1, 65535);
                default: d = $urandom;
            endcase
            a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1000) : $urandom;
            run_op("rand", a, d);
        end

        check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
